fft_stage2_seq: RTL and testbench
=================================

FFT_STAGE2_SEQ -- requirements
Module: fft_stage2_seq

Interface
REQ-001 SHALL have parameter BEATS, default 32: beats per frame (16 samples per beat, 512-point frame).
REQ-002 SHALL have parameter TW_LAT, default 1: cycles from datapath input valid to the twiddle-multiply stage input.
REQ-003 SHALL have parameter PIPE_LAT, default 6: cycles from datapath input valid to CBFP_valid.
REQ-004 SHALL have port clk  input  1  the single clock; all logic rises on clk.
REQ-005 SHALL have port rstn  input  1  synchronous active-high reset (asserted = 1, sampled on clk).
REQ-006 SHALL have port in_valid  input  1  a stage-1 output beat is present.
REQ-007 SHALL have port cbfp_ready  input  1  downstream CBFP can accept a new frame.
REQ-008 SHALL have port in_ready  output  1  the sequencer accepts a beat this cycle.
REQ-009 SHALL have port dp_valid  output  1  drives the stage-2 datapath input valid.
REQ-010 SHALL have port twd_idx  output  $clog2(BEATS)  beat index aligned to the twiddle-stage input.
REQ-011 SHALL have port out_valid  output  1  expected CBFP_valid, for checking and alignment.
REQ-012 SHALL have port out_sof / out_eof  output  1 each  first or last output beat of a frame.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a frame has fully drained.
REQ-014 SHALL have port busy  output  1  state is not IDLE.
REQ-015 SHALL have port frame_cnt  output  16  count of completed frames.

Function
REQ-016 SHALL implement FSM IDLE, RUN and DRAIN.
REQ-017 IDLE: in_ready = cbfp_ready; an accepted beat (in_valid & in_ready) moves the FSM to RUN with in_beat = 1.
REQ-018 RUN: in_ready = 1; each accepted beat increments in_beat; gaps (in_valid = 0) hold in_beat.
REQ-019 RUN: acceptance of beat BEATS-1 moves the FSM to DRAIN and clears in_beat.
REQ-020 DRAIN: in_ready = 0; a drain counter runs PIPE_LAT cycles, then done pulses for 1 cycle, frame_cnt increments (wrapping at 16 bits) and the FSM returns to IDLE.
REQ-021 A beat offered in the same cycle as the return to IDLE is not accepted; acceptance restarts the next cycle.
REQ-022 dp_valid SHALL equal in_valid & in_ready, combinationally, with zero latency.
REQ-023 twd_idx SHALL equal the accepted beat index delayed TW_LAT cycles; it holds its last value while its delayed valid is 0.
REQ-024 out_valid SHALL equal dp_valid delayed exactly PIPE_LAT cycles through a shift register.
REQ-025 An output beat counter SHALL advance on out_valid and wrap at BEATS.
REQ-026 out_sof = out_valid & (count == 0); out_eof = out_valid & (count == BEATS-1).
REQ-027 in_valid while in_ready = 0 SHALL be ignored, with no state change.
REQ-028 A drop of cbfp_ready during RUN SHALL NOT stall the frame already in progress.

Reset
REQ-029 While rstn = 1 the next edge SHALL set: FSM IDLE, all counters 0, shift registers 0, twd_idx 0, frame_cnt 0.
REQ-030 During reset in_ready = 0, and dp_valid, out_valid, out_sof, out_eof, done and busy are all 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; no done pulse, no frame_cnt change.

Configuration
REQ-032 With macro FFT_STAGE2_SEQ_ERR_EN defined: an extra output err (1 bit) SHALL be present.
REQ-033 err sets sticky on in_valid & ~in_ready outside reset, and clears only on reset.
REQ-034 Without FFT_STAGE2_SEQ_ERR_EN: the err port and its logic are absent; all other behaviour is identical.

Verification
REQ-035 Reset, then 32 back-to-back beats, cbfp_ready = 1 -> dp_valid high 32 cycles; out_valid high cycles 6..37 after the first beat; out_sof at the first output beat, out_eof at the last; done 6 cycles after the last accept; frame_cnt = 1.
REQ-036 Beats with one idle cycle between each -> twd_idx steps 0..31 with no skip or repeat; out_eof only on the 32nd output beat.
REQ-037 cbfp_ready = 0 in IDLE with in_valid = 1 -> in_ready = 0, dp_valid = 0, state stays IDLE; ready rises -> acceptance the same cycle.
REQ-038 rstn pulsed after 10 beats -> all outputs 0 next cycle; the next frame starts at twd_idx 0; frame_cnt = 0.
REQ-039 With FFT_STAGE2_SEQ_ERR_EN, in_valid held during DRAIN -> err = 1 and stays set until reset; no extra dp_valid.

Source files
------------

// File: rtl/fft_stage2_seq.sv
// Stage-2 FFT beat sequencer: admits one 512-point frame, tracks twiddle/output alignment, counts frames.
// Define FFT_STAGE2_SEQ_ERR_EN to add a sticky err output for beats offered while not ready.
module fft_stage2_seq #(
  parameter int BEATS    = 32,
  parameter int TW_LAT   = 1,
  parameter int PIPE_LAT = 6
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic                     cbfp_ready,
  output logic                     in_ready,
  output logic                     dp_valid,
  output logic [$clog2(BEATS)-1:0] twd_idx,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     done,
  output logic                     busy,
  output logic [15:0]              frame_cnt
`ifdef FFT_STAGE2_SEQ_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam int IW = $clog2(BEATS);
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [IW-1:0] LAST_BEAT  = IW'(BEATS - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [IW-1:0]              in_beat_q, in_beat_d;
  logic [DW-1:0]              drain_cnt_q, drain_cnt_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic [PIPE_LAT-1:0]        vpipe_q, vpipe_d;
  logic [TW_LAT-1:0]          tw_vld_q, tw_vld_d;
  logic [TW_LAT-1:0][IW-1:0]  tw_idx_q, tw_idx_d;
  logic [IW-1:0]              twd_hold_q, twd_hold_d;
  logic [IW-1:0]              out_cnt_q, out_cnt_d;

  always_comb begin
    state_d     = state_q;
    in_beat_d   = in_beat_q;
    drain_cnt_d = drain_cnt_q;
    frame_cnt_d = frame_cnt_q;
    in_ready    = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = cbfp_ready;
        if (in_valid && cbfp_ready) begin
          state_d   = RUN;
          in_beat_d = IW'(1);
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_beat_q == LAST_BEAT) begin
            state_d   = DRAIN;
            in_beat_d = '0;
          end else begin
            in_beat_d = in_beat_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        // done lands on the cycle the last beat leaves the PIPE_LAT pipeline
        if (drain_cnt_q == LAST_DRAIN) begin
          done        = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          drain_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rstn) begin
      in_ready = 1'b0;
      done     = 1'b0;
    end
  end

  always_comb begin
    dp_valid = in_valid & in_ready;
    busy     = (state_q != IDLE) & ~rstn;
  end

  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = dp_valid;
    for (int unsigned i = 1; i < PIPE_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
    tw_vld_d    = '0;
    tw_idx_d    = '0;
    tw_vld_d[0] = dp_valid;
    tw_idx_d[0] = in_beat_q;
    for (int unsigned i = 1; i < TW_LAT; i++) begin
      tw_vld_d[i] = tw_vld_q[i-1];
      tw_idx_d[i] = tw_idx_q[i-1];
    end
    // index shown at the twiddle stage sticks between valid beats
    twd_idx    = tw_vld_q[TW_LAT-1] ? tw_idx_q[TW_LAT-1] : twd_hold_q;
    twd_hold_d = twd_idx;
  end

  always_comb begin
    out_valid = vpipe_q[PIPE_LAT-1] & ~rstn;
    out_sof   = out_valid & (out_cnt_q == '0);
    out_eof   = out_valid & (out_cnt_q == LAST_BEAT);
    out_cnt_d = out_cnt_q;
    if (out_valid) out_cnt_d = (out_cnt_q == LAST_BEAT) ? '0 : out_cnt_q + IW'(1);
    frame_cnt = frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= IDLE;
      in_beat_q   <= '0;
      drain_cnt_q <= '0;
      frame_cnt_q <= '0;
      vpipe_q     <= '0;
      tw_vld_q    <= '0;
      tw_idx_q    <= '0;
      twd_hold_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_beat_q   <= in_beat_d;
      drain_cnt_q <= drain_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      vpipe_q     <= vpipe_d;
      tw_vld_q    <= tw_vld_d;
      tw_idx_q    <= tw_idx_d;
      twd_hold_q  <= twd_hold_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

`ifdef FFT_STAGE2_SEQ_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (in_valid & ~in_ready);
    err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (rstn) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_fft_stage2_seq.sv
// Self-checking bench for fft_stage2_seq: directed frames plus random traffic against a
// transaction-history reference model (accept log keyed by cycle number).
module tb_fft_stage2_seq;
  localparam int BEATS    = 32;
  localparam int TW_LAT   = 1;
  localparam int PIPE_LAT = 6;

  logic        clk = 1'b0;
  logic        rstn, in_valid, cbfp_ready;
  logic        in_ready, dp_valid, out_valid, out_sof, out_eof, done, busy;
  logic [4:0]  twd_idx;
  logic [15:0] frame_cnt;
`ifdef FFT_STAGE2_SEQ_ERR_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  fft_stage2_seq #(.BEATS(BEATS), .TW_LAT(TW_LAT), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .cbfp_ready(cbfp_ready),
    .in_ready(in_ready), .dp_valid(dp_valid), .twd_idx(twd_idx),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .done(done), .busy(busy), .frame_cnt(frame_cnt)
`ifdef FFT_STAGE2_SEQ_ERR_EN
    , .err(err)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: log of accepted beats (cycle -> beat index) plus frame bookkeeping.
  int cyc      = 0;
  int last_rst = -1;
  int acc_at[int];
  int acc_n    = 0;
  int eof_cyc  = -1;
  int frames   = 0;
  int out_seen = 0;
  bit err_m    = 1'b0;

  // Per-scenario tallies of observed DUT activity.
  int sc_dp, sc_ov, sc_sof, sc_eof;
  int sc_first_dp, sc_last_dp, sc_first_ov, sc_last_ov, sc_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_twd();
    for (int c = cyc - TW_LAT; c > last_rst; c--)
      if (acc_at.exists(c)) return acc_at[c];
    return 0;
  endfunction

  task automatic sc_clear();
    sc_dp = 0; sc_ov = 0; sc_sof = 0; sc_eof = 0;
    sc_first_dp = -1; sc_last_dp = -1; sc_first_ov = -1; sc_last_ov = -1; sc_done = -1;
  endtask

  task automatic cycle(input bit rs, input bit iv, input bit cr);
    bit in_drain, e_rdy, e_dp, e_busy, e_done, e_ov, e_sof, e_eof;
    int src;
    rstn = rs; in_valid = iv; cbfp_ready = cr;
    #4;
    in_drain = (eof_cyc >= 0) && (cyc > eof_cyc) && (cyc <= eof_cyc + PIPE_LAT);
    e_rdy  = rs ? 1'b0 : in_drain ? 1'b0 : (acc_n > 0) ? 1'b1 : cr;
    e_dp   = iv & e_rdy;
    e_busy = !rs && (acc_n > 0 || in_drain);
    e_done = !rs && in_drain && (cyc == eof_cyc + PIPE_LAT);
    src    = cyc - PIPE_LAT;
    e_ov   = !rs && (src > last_rst) && acc_at.exists(src);
    e_sof  = e_ov && (out_seen % BEATS == 0);
    e_eof  = e_ov && (out_seen % BEATS == BEATS - 1);

    chk("in_ready", in_ready, e_rdy);
    chk("dp_valid", dp_valid, e_dp);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("out_valid", out_valid, e_ov);
    chk("out_sof", out_sof, e_sof);
    chk("out_eof", out_eof, e_eof);
    if (last_rst >= 0) begin
      chk("twd_idx", twd_idx, exp_twd());
      chk("frame_cnt", frame_cnt, frames);
`ifdef FFT_STAGE2_SEQ_ERR_EN
      chk("err", err, err_m);
`endif
    end

    if (dp_valid === 1'b1) begin
      sc_dp++; if (sc_first_dp < 0) sc_first_dp = cyc; sc_last_dp = cyc;
    end
    if (out_valid === 1'b1) begin
      sc_ov++; if (sc_first_ov < 0) sc_first_ov = cyc; sc_last_ov = cyc;
    end
    if (out_sof === 1'b1) sc_sof++;
    if (out_eof === 1'b1) sc_eof++;
    if (done === 1'b1) sc_done = cyc;

    if (rs) begin
      last_rst = cyc; acc_n = 0; eof_cyc = -1; frames = 0; out_seen = 0; err_m = 1'b0;
    end else begin
      if (e_dp) begin
        acc_at[cyc] = acc_n;
        acc_n++;
        if (acc_n == BEATS) begin acc_n = 0; eof_cyc = cyc; end
      end
      if (e_done) frames = (frames + 1) % 65536;
      if (e_ov) out_seen++;
      if (iv && !e_rdy) err_m = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    rstn = 1'b1; in_valid = 1'b0; cbfp_ready = 1'b0;
    @(posedge clk); #1;

    // Reset with traffic offered: nothing may be accepted.
    cycle(1, 1, 1);
    cycle(1, 1, 1);

    // One frame back-to-back.
    sc_clear();
    for (int i = 0; i < BEATS; i++) cycle(0, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    chk("s2_dp_cnt", sc_dp, BEATS);
    chk("s2_ov_cnt", sc_ov, BEATS);
    chk("s2_ov_first", sc_first_ov - sc_first_dp, PIPE_LAT);
    chk("s2_ov_last", sc_last_ov - sc_first_dp, PIPE_LAT + BEATS - 1);
    chk("s2_done_lat", sc_done - sc_last_dp, PIPE_LAT);
    chk("s2_sof_eof", {sc_sof[15:0], sc_eof[15:0]}, {16'd1, 16'd1});
    chk("s2_frame_cnt", frame_cnt, 1);

    // One idle cycle between beats.
    sc_clear();
    for (int i = 0; i < BEATS; i++) begin cycle(0, 1, 1); cycle(0, 0, 1); end
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    chk("gap_dp_cnt", sc_dp, BEATS);
    chk("gap_eof_cnt", sc_eof, 1);
    chk("gap_frame_cnt", frame_cnt, 2);

    // in_valid held through drain and the return to idle.
    for (int i = 0; i < BEATS + PIPE_LAT + 3; i++) cycle(0, 1, 1);
    for (int i = 0; i < BEATS - 3; i++) cycle(0, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);

    // Downstream not ready in idle, then ready; ready toggling mid-frame.
    sc_clear();
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    chk("rdy_low_dp_cnt", sc_dp, 0);
    cycle(0, 1, 1);
    chk("rdy_rise_accept", sc_dp, 1);
    for (int i = 0; i < BEATS - 1; i++) cycle(0, 1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);

    // Reset after 10 beats, then a fresh frame.
    for (int i = 0; i < 10; i++) cycle(0, 1, 1);
    cycle(1, 1, 1);
    sc_clear();
    cycle(0, 0, 1);
    chk("post_rst_quiet", {out_valid, done, busy, twd_idx}, '0);
    chk("post_rst_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < BEATS; i++) cycle(0, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    chk("post_rst_frame_done", frame_cnt, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++)
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
